// File: rtl/inst_class_queue_pkg.sv
// Shared instruction definitions: type codes, type width and the
// dispatch-class constants used by the class queue, ROB and LSB.
package inst_class_queue_pkg;

  localparam int INST_TYPE_WIDTH = 6;
  typedef logic [INST_TYPE_WIDTH-1:0] inst_type_t;

  localparam inst_type_t TYPE_NOP   = 6'd0;
  localparam inst_type_t TYPE_LUI   = 6'd1;
  localparam inst_type_t TYPE_AUIPC = 6'd2;
  localparam inst_type_t TYPE_JAL   = 6'd3;
  localparam inst_type_t TYPE_JALR  = 6'd4;
  localparam inst_type_t TYPE_BEQ   = 6'd5;
  localparam inst_type_t TYPE_BNE   = 6'd6;
  localparam inst_type_t TYPE_BLT   = 6'd7;
  localparam inst_type_t TYPE_BGE   = 6'd8;
  localparam inst_type_t TYPE_BLTU  = 6'd9;
  localparam inst_type_t TYPE_BGEU  = 6'd10;
  localparam inst_type_t TYPE_LB    = 6'd11;
  localparam inst_type_t TYPE_LH    = 6'd12;
  localparam inst_type_t TYPE_LW    = 6'd13;
  localparam inst_type_t TYPE_LBU   = 6'd14;
  localparam inst_type_t TYPE_LHU   = 6'd15;
  localparam inst_type_t TYPE_SB    = 6'd16;
  localparam inst_type_t TYPE_SH    = 6'd17;
  localparam inst_type_t TYPE_SW    = 6'd18;
  localparam inst_type_t TYPE_ADDI  = 6'd19;
  localparam inst_type_t TYPE_SLTI  = 6'd20;
  localparam inst_type_t TYPE_SLTIU = 6'd21;
  localparam inst_type_t TYPE_XORI  = 6'd22;
  localparam inst_type_t TYPE_ORI   = 6'd23;
  localparam inst_type_t TYPE_ANDI  = 6'd24;
  localparam inst_type_t TYPE_SLLI  = 6'd25;
  localparam inst_type_t TYPE_SRLI  = 6'd26;
  localparam inst_type_t TYPE_SRAI  = 6'd27;
  localparam inst_type_t TYPE_ADD   = 6'd28;
  localparam inst_type_t TYPE_SUB   = 6'd29;
  localparam inst_type_t TYPE_SLL   = 6'd30;
  localparam inst_type_t TYPE_SLT   = 6'd31;
  localparam inst_type_t TYPE_SLTU  = 6'd32;
  localparam inst_type_t TYPE_XOR   = 6'd33;
  localparam inst_type_t TYPE_SRL   = 6'd34;
  localparam inst_type_t TYPE_SRA   = 6'd35;
  localparam inst_type_t TYPE_OR    = 6'd36;
  localparam inst_type_t TYPE_AND   = 6'd37;

  localparam int CLASS_WIDTH = 2;
  typedef enum logic [CLASS_WIDTH-1:0] {
    CLASS_CALC   = 2'd0,
    CLASS_MEM    = 2'd1,
    CLASS_BRANCH = 2'd2,
    CLASS_OTHER  = 2'd3
  } inst_class_e;

endpackage

// File: rtl/inst_classifier.sv
// Purely combinational instruction-type to dispatch-class mapping.
// Shared by the class queue, ROB and LSB; unknown codes map to OTHER.
module inst_classifier
  import inst_class_queue_pkg::*;
(
  input  logic [INST_TYPE_WIDTH-1:0] type_in,
  output inst_class_e                class_out
);

  // Map each type code to the unit class that executes it
  always_comb begin
    class_out = CLASS_OTHER;
    case (type_in)
      TYPE_LUI, TYPE_AUIPC, TYPE_ADD, TYPE_SUB, TYPE_SLL, TYPE_SLT,
      TYPE_SLTU, TYPE_XOR, TYPE_SRL, TYPE_SRA, TYPE_OR, TYPE_AND,
      TYPE_ADDI, TYPE_SLTI, TYPE_SLTIU, TYPE_XORI, TYPE_ORI, TYPE_ANDI,
      TYPE_SLLI, TYPE_SRLI, TYPE_SRAI:
        class_out = CLASS_CALC;
      TYPE_LB, TYPE_LH, TYPE_LW, TYPE_LBU, TYPE_LHU,
      TYPE_SB, TYPE_SH, TYPE_SW:
        class_out = CLASS_MEM;
      TYPE_JAL, TYPE_JALR, TYPE_BEQ, TYPE_BNE, TYPE_BLT, TYPE_BGE,
      TYPE_BLTU, TYPE_BGEU:
        class_out = CLASS_BRANCH;
      default:
        class_out = CLASS_OTHER;
    endcase
  end

endmodule

// File: rtl/inst_class_queue.sv
// In-order decoder-to-issue buffer. Each entry is classified on entry and
// the head is dispatched only when the unit for its class is ready; a
// blocked head stalls everything behind it. flush_in empties the queue.
// Optional per-class dispatch and stall counters: define INST_CLASS_STATS_EN.
module inst_class_queue
  import inst_class_queue_pkg::*;
#(
  parameter int TYPE_W    = 6,
  parameter int PAYLOAD_W = 64,
  parameter int DEPTH     = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         flush_in,
  input  logic                         in_valid,
  input  logic [TYPE_W-1:0]            in_type,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [CLASS_WIDTH-1:0]       out_class,
  output logic [TYPE_W-1:0]            out_type,
  output logic [PAYLOAD_W-1:0]         out_payload,
  input  logic [3:0]                   class_ready,
`ifdef INST_CLASS_STATS_EN
  output logic [3:0][31:0]             stat_cnt,
  output logic [31:0]                  stall_cnt,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic                   vld;
    logic [CLASS_WIDTH-1:0] cls;
    logic [TYPE_W-1:0]      typ;
    logic [PAYLOAD_W-1:0]   payload;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           head_e;
  inst_class_e      in_class;
  logic             push, pop;

  inst_classifier u_classifier (
    .type_in   (in_type),
    .class_out (in_class)
  );

  assign head_e      = mem_q[head_q];
  assign out_valid   = (count_q != '0) && head_e.vld;
  assign out_class   = head_e.cls;
  assign out_type    = head_e.typ;
  assign out_payload = head_e.payload;
  assign in_ready    = (count_q != FULL_CNT);
  assign count       = count_q;
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && class_ready[head_e.cls];

  // Next-state for storage, pointers and occupancy; flush overrides all
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_in) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i].vld = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = '{vld: 1'b1, cls: in_class, typ: in_type, payload: in_payload};
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop) begin
        mem_d[head_q].vld = 1'b0;
        head_d            = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state registers; reset empties every entry at once
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef INST_CLASS_STATS_EN
  logic [3:0][31:0] stat_cnt_q, stat_cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  assign stat_cnt  = stat_cnt_q;
  assign stall_cnt = stall_cnt_q;

  // Count dispatches per class and blocked-head cycles; flush cycles ignored
  always_comb begin
    stat_cnt_d  = stat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!flush_in) begin
      if (pop) stat_cnt_d[head_e.cls] = stat_cnt_q[head_e.cls] + 32'd1;
      if (out_valid && !class_ready[head_e.cls]) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Statistics registers survive flush, clear only on reset
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      stat_cnt_q  <= stat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_inst_class_queue.sv
// Directed testbench for inst_class_queue (DEPTH=4).
module tb_inst_class_queue;
  import inst_class_queue_pkg::*;

  localparam int TYPE_W    = 6;
  localparam int PAYLOAD_W = 64;
  localparam int DEPTH     = 4;
  localparam int CNT_W     = $clog2(DEPTH+1);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush_in;
  logic                 in_valid;
  logic [TYPE_W-1:0]    in_type;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 in_ready;
  logic                 out_valid;
  logic [1:0]           out_class;
  logic [TYPE_W-1:0]    out_type;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [3:0]           class_ready;
  logic [CNT_W-1:0]     count;
`ifdef INST_CLASS_STATS_EN
  logic [3:0][31:0]     stat_cnt;
  logic [31:0]          stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_class_queue #(.TYPE_W(TYPE_W), .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH)) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .flush_in    (flush_in),
    .in_valid    (in_valid),
    .in_type     (in_type),
    .in_payload  (in_payload),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_class   (out_class),
    .out_type    (out_type),
    .out_payload (out_payload),
    .class_ready (class_ready),
`ifdef INST_CLASS_STATS_EN
    .stat_cnt    (stat_cnt),
    .stall_cnt   (stall_cnt),
`endif
    .count       (count)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_in = 1'b0; in_valid = 1'b0; in_type = '0;
    in_payload = '0; class_ready = '0;
    cyc(); cyc();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (out_class !== 2'd0) begin errors++; $display("FAIL reset_out_class: got %0d want 0", out_class); end
    checks++; if (out_payload !== 64'h0) begin errors++; $display("FAIL reset_out_payload: got %0h want 0", out_payload); end
    rst_n = 1'b1;
    cyc();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL idle: count %0d out_valid %0b want 0 0", count, out_valid); end
  endtask

  task automatic test_single();
    class_ready = 4'b0000;
    in_valid = 1'b1; in_type = TYPE_ADD; in_payload = 64'h11;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_passthrough: got %0b want 0", out_valid); end
    cyc();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", out_valid); end
    checks++; if (out_class !== 2'd0) begin errors++; $display("FAIL single_class: got %0d want 0", out_class); end
    checks++; if (out_type !== TYPE_ADD) begin errors++; $display("FAIL single_type: got %0d want %0d", out_type, TYPE_ADD); end
    checks++; if (out_payload !== 64'h11) begin errors++; $display("FAIL single_payload: got %0h want 11", out_payload); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count); end
    class_ready = 4'b0001;
    cyc();
    class_ready = 4'b0000;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_pop: count %0d out_valid %0b want 0 0", count, out_valid); end
  endtask

  task automatic test_order();
    logic [TYPE_W-1:0] types [4];
    logic [1:0]        exp_cls [4];
    types[0] = TYPE_LW;  exp_cls[0] = 2'd1;
    types[1] = TYPE_BEQ; exp_cls[1] = 2'd2;
    types[2] = 6'd40;    exp_cls[2] = 2'd3;
    types[3] = TYPE_SUB; exp_cls[3] = 2'd0;
    class_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_type = types[i]; in_payload = 64'h21 + 64'(i);
      cyc();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL order_fill: got %0d want 4", count); end
    class_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_class !== exp_cls[i]) begin errors++; $display("FAIL order_class[%0d]: got %0d want %0d", i, out_class, exp_cls[i]); end
      checks++; if (out_payload !== 64'h21 + 64'(i)) begin errors++; $display("FAIL order_payload[%0d]: got %0h want %0h", i, out_payload, 64'h21 + 64'(i)); end
      cyc();
    end
    class_ready = 4'b0000;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL order_drain: got %0d want 0", count); end
  endtask

  task automatic test_full();
    class_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_type = TYPE_ADD; in_payload = 64'h30 + 64'(i);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_accept[%0d]: got %0b want 1", i, in_ready); end
      cyc();
    end
    in_payload = 64'h34;
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL full_state: count %0d in_ready %0b want 4 0", count, in_ready); end
    cyc();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_hold: got %0d want 4", count); end
    class_ready = 4'b0001;
    cyc();
    class_ready = 4'b0000;
    checks++; if (count !== 3'd3 || in_ready !== 1'b1) begin errors++; $display("FAIL full_no_bypass: count %0d in_ready %0b want 3 1", count, in_ready); end
    checks++; if (out_payload !== 64'h31) begin errors++; $display("FAIL full_head: got %0h want 31", out_payload); end
    cyc();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_late_accept: got %0d want 4", count); end
    class_ready = 4'b1111;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (out_payload !== 64'h30 + 64'(i)) begin errors++; $display("FAIL full_drain[%0d]: got %0h want %0h", i, out_payload, 64'h30 + 64'(i)); end
      cyc();
    end
    class_ready = 4'b0000;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d want 0", count); end
  endtask

  task automatic test_blocked();
    class_ready = 4'b1101;
    in_valid = 1'b1; in_type = TYPE_LW; in_payload = 64'hA0;
    cyc();
    in_type = TYPE_ADDI; in_payload = 64'hA1;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (count !== 3'd2 || out_payload !== 64'hA0) begin errors++; $display("FAIL blocked_stall[%0d]: count %0d head %0h want 2 a0", i, count, out_payload); end
      cyc();
    end
    class_ready = 4'b1111;
    cyc();
    checks++; if (count !== 3'd1 || out_payload !== 64'hA1 || out_class !== 2'd0) begin errors++; $display("FAIL blocked_release: count %0d head %0h class %0d want 1 a1 0", count, out_payload, out_class); end
    cyc();
    class_ready = 4'b0000;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL blocked_drain: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    class_ready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_type = TYPE_ADD; in_payload = 64'h50 + 64'(i);
      cyc();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_fill: got %0d want 3", count); end
    in_payload = 64'hFF; flush_in = 1'b1; class_ready = 4'b1111;
    cyc();
    flush_in = 1'b0; in_valid = 1'b0; class_ready = 4'b0000;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_clear: count %0d out_valid %0b in_ready %0b want 0 0 1", count, out_valid, in_ready); end
    cyc();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_push_dropped: got %0d want 0", count); end
    in_valid = 1'b1; in_type = TYPE_SW; in_payload = 64'h60;
    cyc();
    in_valid = 1'b0;
    checks++; if (count !== 3'd1 || out_payload !== 64'h60 || out_class !== 2'd1) begin errors++; $display("FAIL flush_refill: count %0d head %0h class %0d want 1 60 1", count, out_payload, out_class); end
    flush_in = 1'b1;
    cyc();
    flush_in = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_again: got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    logic [TYPE_W-1:0] types [13];
    logic [1:0]        exp_cls [13];
    int                exp_tot [4];
    int                exp_stall;
    types[0]  = TYPE_ADD; types[1]  = TYPE_LW;  types[2]  = TYPE_BEQ; types[3]  = 6'd63;
    types[4]  = TYPE_SUB; types[5]  = TYPE_SW;  types[6]  = TYPE_JAL; types[7]  = TYPE_NOP;
    types[8]  = TYPE_LUI; types[9]  = TYPE_LB;  types[10] = TYPE_BNE; types[11] = 6'd40;
    types[12] = TYPE_AND;
    for (int i = 0; i < 13; i++) exp_cls[i] = 2'(i % 4);
    for (int c = 0; c < 4; c++) exp_tot[c] = 0;
    for (int i = 0; i < 13; i++) exp_tot[exp_cls[i]]++;
    exp_stall = 0;

    // mid-operation asynchronous reset
    class_ready = 4'b0000;
    in_valid = 1'b1; in_type = TYPE_ADD; in_payload = 64'h77;
    cyc(); cyc();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL async_reset: count %0d out_valid %0b want 0 0", count, out_valid); end
    cyc();
    rst_n = 1'b1;
    cyc();
    checks++; if (count !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_release: count %0d in_ready %0b want 0 1", count, in_ready); end

    in_valid = 1'b1; in_type = types[0]; in_payload = 64'h100;
    cyc();
    for (int i = 1; i <= 12; i++) begin
      in_valid = 1'b1; in_type = types[i]; in_payload = 64'h100 + 64'(i);
      class_ready = 4'b1111;
      checks++; if (out_payload !== 64'h100 + 64'(i-1) || out_class !== exp_cls[i-1]) begin errors++; $display("FAIL wrap_head[%0d]: head %0h class %0d want %0h %0d", i-1, out_payload, out_class, 64'h100 + 64'(i-1), exp_cls[i-1]); end
      cyc();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count[%0d]: got %0d want 1", i, count); end
      if (i % 4 == 0) begin
        in_valid = 1'b0; class_ready = 4'b0000;
        cyc();
        exp_stall++;
        checks++; if (out_payload !== 64'h100 + 64'(i)) begin errors++; $display("FAIL wrap_stall[%0d]: got %0h want %0h", i, out_payload, 64'h100 + 64'(i)); end
      end
    end
    in_valid = 1'b0; class_ready = 4'b1111;
    checks++; if (out_payload !== 64'h10C || out_class !== exp_cls[12]) begin errors++; $display("FAIL wrap_last: head %0h class %0d want 10c %0d", out_payload, out_class, exp_cls[12]); end
    cyc();
    class_ready = 4'b0000;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_empty: got %0d want 0", count); end
`ifdef INST_CLASS_STATS_EN
    for (int c = 0; c < 4; c++) begin
      checks++; if (stat_cnt[c] !== 32'(exp_tot[c])) begin errors++; $display("FAIL stat_cnt[%0d]: got %0d want %0d", c, stat_cnt[c], exp_tot[c]); end
    end
    checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_full();
    test_blocked();
    test_flush();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_class_queue.md
Name: inst_class_queue

Overview:
- Parametrised in-order buffer between decoder and issue logic.
- Classifies each enqueued instruction type into CALC / MEM / BRANCH / OTHER and stores the class alongside it.
- Dispatches the head entry only when the unit serving that class is ready.
- Supersedes the single-bit combinational calc classifier: multi-class, buffered, with handshakes and flush.

Parameters:
- TYPE_W, 6: instruction-type code width; must equal the shared INST_TYPE_WIDTH.
- PAYLOAD_W, 64: opaque per-instruction payload (pc, rd, rs1, rs2, imm tag, ...), carried unchanged.
- DEPTH, 4: number of entries; power of two, at least 2.

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  asynchronous active-low reset
- flush_in  in  1  synchronous clear; used on branch mispredict
- in_valid  in  1  enqueue request
- in_type  in  TYPE_W  instruction type code
- in_payload  in  PAYLOAD_W  payload
- in_ready  out  1  queue can accept an entry
- out_valid  out  1  head entry present
- out_class  out  2  head class: 0=CALC, 1=MEM, 2=BRANCH, 3=OTHER
- out_type  out  TYPE_W  head type
- out_payload  out  PAYLOAD_W  head payload
- class_ready  in  4  per-class consumer ready, indexed by class
- count  out  clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (async assert, sync release):
  - head, tail and count are 0; every storage entry holds valid=0.
  - out_valid=0, in_ready=1; out_class, out_type and out_payload are 0.
- Classification happens combinationally on in_type at enqueue and is stored with the entry:
  - CALC = LUI, AUIPC, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - MEM = LB, LH, LW, LBU, LHU, SB, SH, SW.
  - BRANCH = JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - OTHER = any other code, including the undefined/NOP code.
- Push occurs when in_valid && in_ready. in_ready = (count != DEPTH). There is no full-bypass: a full queue refuses the push even when a pop happens in the same cycle.
- Pop occurs when out_valid && class_ready[out_class].
  - out_* are driven from head storage, so they are registered-stage outputs.
  - out_valid = (count != 0).
  - Entry latency: a pushed entry is visible at the head at the earliest on the next cycle. There is no same-cycle pass-through.
- Simultaneous push and pop, when not full and not empty: count is unchanged, both pointers advance.
- Pointers are clog2(DEPTH) bits wide and wrap naturally modulo DEPTH; count distinguishes full from empty.
- Strict in-order dispatch: a blocked head (its class not ready) stalls every younger entry, whatever their class.
- flush_in has priority over push and pop in the same cycle:
  - Next cycle: count=0, head=tail=0, out_valid=0.
  - A push presented in the flush cycle is dropped.
  - A pop in the flush cycle is not counted.
- Consumer requirement: class_ready must not depend combinationally on out_valid of this block.
- Reset asserted mid-operation discards all contents immediately.

Optional Feature:
- Macro: INST_CLASS_STATS_EN.
- When defined:
  - Adds output stat_cnt, 4 x 32 bits: per-class counters of popped (dispatched) entries, plus one 32-bit stall_cnt.
  - stall_cnt increments on each cycle with out_valid && !class_ready[out_class] && !flush_in.
  - All counters wrap at 2^32, clear on reset, and are not cleared by flush.
- When undefined: these ports and registers are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package/header (the existing info.v):
  - instruction type codes and INST_TYPE_WIDTH.
  - New class constants: CLASS_CALC=0, CLASS_MEM=1, CLASS_BRANCH=2, CLASS_OTHER=3, CLASS_WIDTH=2.
- Sub-module: inst_classifier, purely combinational, type -> 2-bit class.
  - Reused later by the ROB and the LSB.
  - The queue instantiates it once, on the input side.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, count=0. Push ADD with payload 0x11 -> next cycle out_valid=1, out_class=0, out_payload=0x11.
- Push LW, BEQ, ECALL-like undefined code, SUB with class_ready=4'b1111 -> popped classes in order 1, 2, 3, 0; count returns to 0.
- DEPTH=4: push 5 entries with class_ready=0 -> 4 accepted, in_ready=0, count=4. Fifth is held until one pop, then accepted the cycle after.
- Head LW with class_ready=4'b1101 (MEM not ready), ADDI behind it -> no pop for 10 cycles, count stays 2. Raise bit 1 -> LW pops, then ADDI.
- Queue holds 3 entries; assert flush_in together with in_valid and a pop -> next cycle count=0, out_valid=0; the flush-cycle push is absent.
- Run 3*DEPTH+1 push/pop pairs so the pointers wrap -> payloads emerge in order; with INST_CLASS_STATS_EN defined, per-class totals match the pushed mix and stall_cnt equals the number of forced-stall cycles.
